// File: rtl/ecd_wb_stream_bridge_if.sv
// ecd_wb_stream_bridge_if
//   Wishbone classic slave bundle between the Caravel wrapper and the
//   stream bridge.
//   master : drives cyc/stb/we/sel/adr/dat_i, samples ack/dat_o
//   slave  : samples cyc/stb/we/sel/adr/dat_i, drives ack/dat_o
interface ecd_wb_stream_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ecd_wb_stream_bridge.sv
// ecd_wb_stream_bridge
//   Wishbone slave exposing a CPU->logic TX byte FIFO and a logic->CPU RX
//   byte FIFO, plus three level interrupts.
//   Ports:
//     wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//     wb                 : Wishbone slave bundle (registered ack and data)
//     tx_data/tx_valid/tx_ready : TX stream out
//     rx_data/rx_valid   : RX push strobe in (no back-pressure)
//     irq[2:0]           : registered interrupts (rx-nonempty, tx-empty, ovf)
//   Registers (offset = adr[3:2]): 0 DATA, 1 STATUS, 2 IRQ_EN, 3 IRQ_STAT.
//
//   Handshake: the TX stream transfers one byte on every rising edge where
//   tx_valid and tx_ready are both high; tx_valid never depends on
//   tx_ready, and tx_data is stable while tx_valid is high and not taken.
//   rx_valid is a push strobe with no ready: a byte arriving while RX is
//   full is dropped and recorded in rx_ovf.
module ecd_wb_stream_bridge #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  ecd_wb_stream_bridge_if.slave  wb,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [2:0]             irq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          ack_q;
  logic [31:0]   dat_q;
  logic [2:0]    irq_en;
  logic [1:0]    irq_stat;    // {tx_ovf, rx_ovf}

  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] tx_cnt;
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] rx_cnt;

  // Decode. Gating with ack_q makes a strobe held through the ack cycle
  // complete only once, so back-to-back accesses take two cycles each.
  logic       hit, wr_acc, rd_acc;
  logic [1:0] off;
  assign hit    = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q &
                  (wb.wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign off    = wb.wbs_adr_i[3:2];
  assign wr_acc = hit & wb.wbs_we_i;
  assign rd_acc = hit & ~wb.wbs_we_i;

  // Full/empty come from the count before this edge's updates.
  logic tx_full, tx_empty, rx_full, rx_empty;
  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  logic tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
  assign tx_push_req = wr_acc & (off == 2'd0) & wb.wbs_sel_i[0];
  assign tx_push     = tx_push_req & ~tx_full;   // full: dropped even if popping
  assign tx_pop      = ~tx_empty & tx_ready;
  assign rx_push     = rx_valid & ~rx_full;      // full: dropped even if popping
  assign rx_pop      = rd_acc & (off == 2'd0) & ~rx_empty;

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rd_ptr];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) tx_mem[i] <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr_ptr] <= wb.wbs_dat_i[7:0];
        tx_wr_ptr         <= tx_wr_ptr + 1'b1;
      end
      if (tx_pop) tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wr_ptr] <= rx_data;
        rx_wr_ptr         <= rx_wr_ptr + 1'b1;
      end
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Counts are placed at [12:8] and [20:16]; fields fit for DEPTH <= 16.
  logic [31:0] status, rdata;
  always_comb begin
    status              = '0;
    status[0]           = tx_full;
    status[1]           = tx_empty;
    status[2]           = rx_full;
    status[3]           = rx_empty;
    status[8  +: CW]    = tx_cnt;
    status[16 +: CW]    = rx_cnt;
  end

  always_comb begin
    rdata = '0;
    unique case (off)
      2'd0:    rdata = rx_empty ? 32'h0 : {1'b1, 23'b0, rx_mem[rx_rd_ptr]};
      2'd1:    rdata = status;
      2'd2:    rdata = {29'b0, irq_en};
      default: rdata = {30'b0, irq_stat};
    endcase
  end

  // Overflow flags are sticky; a set in the same edge as a W1C wins.
  logic [1:0] stat_set, stat_clr;
  assign stat_set = {tx_push_req & tx_full, rx_valid & rx_full};
  assign stat_clr = (wr_acc && off == 2'd3 && wb.wbs_sel_i[0]) ?
                    wb.wbs_dat_i[1:0] : 2'b00;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_en   <= '0;
      irq_stat <= '0;
      irq      <= '0;
    end else begin
      ack_q    <= hit;
      dat_q    <= rd_acc ? rdata : 32'h0;
      if (wr_acc && off == 2'd2 && wb.wbs_sel_i[0]) irq_en <= wb.wbs_dat_i[2:0];
      irq_stat <= (irq_stat & ~stat_clr) | stat_set;
      // Sampled from current state, so irq trails FIFO changes by one edge.
      irq      <= {irq_en[2] & (|irq_stat), irq_en[1] & tx_empty,
                   irq_en[0] & ~rx_empty};
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

  wire unused_bits = ^{wb.wbs_sel_i[3:1], wb.wbs_adr_i[1:0],
                       wb.wbs_dat_i[31:8]};
endmodule

// File: tb/tb_ecd_wb_stream_bridge.sv
module tb_ecd_wb_stream_bridge;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_IEN  = BASE + 32'h8;
  localparam logic [31:0] A_IST  = BASE + 32'hC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ecd_wb_stream_bridge_if wb ();
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data  = 8'h0;
  logic       rx_valid = 1'b0;
  logic [2:0] irq;

  ecd_wb_stream_bridge #(.DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (wb),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .irq      (irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Two byte queues plus the architectural registers; each edge applies
  // the register-map rules to the inputs seen at that edge.
  logic [7:0]  m_txq[$];
  logic [7:0]  m_rxq[$];
  logic [2:0]  m_en;
  logic        m_rx_ovf, m_tx_ovf;
  logic        m_ack;
  logic [31:0] m_dat;
  logic [2:0]  m_irq;

  always @(posedge clk or posedge rst) begin : model
    int          tx_n, rx_n;
    logic        acc;
    logic [1:0]  off;
    logic [31:0] rd;
    logic [2:0]  nirq;
    if (rst) begin
      m_txq.delete(); m_rxq.delete();
      m_en = 0; m_rx_ovf = 0; m_tx_ovf = 0; m_ack = 0; m_dat = 0; m_irq = 0;
    end else begin
      tx_n = m_txq.size();
      rx_n = m_rxq.size();
      acc  = wb.wbs_cyc_i && wb.wbs_stb_i && !m_ack &&
             (wb.wbs_adr_i[31:4] == BASE[31:4]);
      off  = wb.wbs_adr_i[3:2];
      nirq = {m_en[2] & (m_rx_ovf | m_tx_ovf), m_en[1] & (tx_n == 0),
              m_en[0] & (rx_n != 0)};
      rd = 0;
      if (acc && !wb.wbs_we_i) begin
        case (off)
          2'd0: rd = (rx_n != 0) ? (32'h8000_0000 | 32'(m_rxq[0])) : 32'h0;
          2'd1: rd = 32'(tx_n == DEPTH) | (32'(tx_n == 0) << 1) |
                     (32'(rx_n == DEPTH) << 2) | (32'(rx_n == 0) << 3) |
                     (32'(tx_n) << 8) | (32'(rx_n) << 16);
          2'd2: rd = 32'(m_en);
          default: rd = 32'(m_tx_ovf) * 2 + 32'(m_rx_ovf);
        endcase
      end
      if (acc && wb.wbs_we_i && off == 2'd3 && wb.wbs_sel_i[0]) begin
        if (wb.wbs_dat_i[0]) m_rx_ovf = 0;
        if (wb.wbs_dat_i[1]) m_tx_ovf = 0;
      end
      if (tx_n > 0 && tx_ready) void'(m_txq.pop_front());
      if (acc && wb.wbs_we_i && off == 2'd0 && wb.wbs_sel_i[0]) begin
        if (tx_n == DEPTH) m_tx_ovf = 1;
        else m_txq.push_back(wb.wbs_dat_i[7:0]);
      end
      if (acc && !wb.wbs_we_i && off == 2'd0 && rx_n > 0) void'(m_rxq.pop_front());
      if (rx_valid) begin
        if (rx_n == DEPTH) m_rx_ovf = 1;
        else m_rxq.push_back(rx_data);
      end
      if (acc && wb.wbs_we_i && off == 2'd2 && wb.wbs_sel_i[0]) m_en = wb.wbs_dat_i[2:0];
      m_irq = nirq;
      m_ack = acc;
      m_dat = rd;
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("ack", 32'(wb.wbs_ack_o), 32'(m_ack));
      chk("dat_o", wb.wbs_dat_o, m_dat);
      chk("tx_valid", 32'(tx_valid), 32'(m_txq.size() != 0));
      chk("irq", 32'(irq), 32'(m_irq));
      if (m_txq.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_txq[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rdata, output logic got);
    @(negedge clk);
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = we;
    wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = adr; wb.wbs_dat_i = dat;
    got = 0; rdata = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb.wbs_ack_o) begin
        got = 1; rdata = wb.wbs_dat_o;
        break;
      end
    end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] r; logic g;
    wb_xfer(1'b1, adr, dat, r, g);
    chk("wr_ack", 32'(g), 32'd1);
  endtask

  task automatic wb_rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r; logic g;
    wb_xfer(1'b0, adr, 32'h0, r, g);
    chk({name, "_ack"}, 32'(g), 32'd1);
    chk(name, r, exp);
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1; rx_data = b;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ack"}, 32'(wb.wbs_ack_o), 32'd0);
    chk({tag, "_dat"}, wb.wbs_dat_o, 32'd0);
    chk({tag, "_txv"}, 32'(tx_valid), 32'd0);
    chk({tag, "_txd"}, 32'(tx_data), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] exp_q[$];

  initial begin
    logic [31:0] r; logic g;
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb.wbs_sel_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;

    // Power-on reset
    #2 rst = 1;
    #1 check_outputs_zero("por");
    repeat (2) @(negedge clk);
    rst = 0;
    wb_rd("status_por", A_STAT, 32'h0000_000A);

    // TX path
    wb_wr(A_DATA, 32'hA5);
    wb_wr(A_DATA, 32'h3C);
    wb_rd("status_tx2", A_STAT, 32'h0000_0208);
    @(negedge clk);
    chk("tx_head0", {23'b0, tx_valid, tx_data}, 32'h1A5);
    tx_ready = 1;
    @(negedge clk);
    chk("tx_head1", {23'b0, tx_valid, tx_data}, 32'h13C);
    @(negedge clk);
    chk("tx_drained", 32'(tx_valid), 32'd0);
    tx_ready = 0;

    // TX full / overflow
    for (int i = 0; i < 17; i++) wb_wr(A_DATA, 32'(8'h10 + i));
    wb_rd("status_txfull", A_STAT, 32'h0000_1009);
    wb_rd("irqstat_txovf", A_IST, 32'h0000_0002);
    wb_wr(A_IST, 32'h2);
    wb_rd("irqstat_clr", A_IST, 32'h0000_0000);
    @(negedge clk);
    chk("tx_full_head", 32'(tx_data), 32'h10);
    tx_ready = 1;
    repeat (17) @(negedge clk);
    tx_ready = 0;

    // Asynchronous reset mid-cycle with live outputs
    rx_push(8'h55);
    wb_wr(A_IEN, 32'h1);
    wb_wr(A_DATA, 32'h77);
    @(negedge clk);
    chk("pre_rst_live", {28'b0, irq, tx_valid}, 32'h3);
    #3 rst = 1;
    #1 check_outputs_zero("midrst");
    @(negedge clk);
    rst = 0;
    wb_rd("status_rst", A_STAT, 32'h0000_000A);

    // RX path with rx-nonempty interrupt
    wb_wr(A_IEN, 32'h1);
    rx_push(8'h11);
    chk("irq0_lag", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq0_rise", 32'(irq), 32'd1);
    rx_push(8'h22);
    wb_rd("rx_rd0", A_DATA, 32'h8000_0011);
    wb_rd("rx_rd1", A_DATA, 32'h8000_0022);
    wb_rd("rx_rd_empty", A_DATA, 32'h0000_0000);
    chk("irq0_fall", 32'(irq), 32'd0);

    // RX overflow coinciding with a CPU pop
    wb_wr(A_IEN, 32'h4);
    for (int i = 0; i < 16; i++) rx_push(8'(8'h40 + i));
    @(negedge clk);
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 0;
    wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = A_DATA;
    rx_valid = 1; rx_data = 8'h99;
    @(negedge clk);
    rx_valid = 0;
    chk("ovf_pop_ack", 32'(wb.wbs_ack_o), 32'd1);
    chk("ovf_pop_dat", wb.wbs_dat_o, 32'h8000_0040);
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0;
    wb_rd("status_rxovf", A_STAT, 32'h000F_0002);
    wb_rd("irqstat_rxovf", A_IST, 32'h0000_0001);
    chk("irq2", 32'(irq), 32'd4);
    for (int i = 1; i < 16; i++) wb_rd("rx_drain", A_DATA, 32'h8000_0040 + 32'(i));
    wb_wr(A_IST, 32'h1);
    wb_wr(A_IEN, 32'h0);

    // Interleaved traffic through pointer wrap
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = 8'(8'hC0 ^ (i * 7));
      exp_q.push_back(b);
      rx_push(b);
      tx_ready = i[0];
      wb_wr(A_DATA, 32'(8'(i * 3 + 1)));
      if (i[0]) begin
        for (int k = 0; k < 2; k++) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          wb_rd("wrap_rx", A_DATA, 32'h8000_0000 | 32'(e));
        end
      end
    end
    tx_ready = 1;
    repeat (20) @(negedge clk);
    chk("wrap_tx_done", 32'(tx_valid), 32'd0);
    tx_ready = 0;

    // Decode miss just past the window
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, r, g);
    chk("miss_no_ack", 32'(g), 32'd0);
    wb_xfer(1'b1, BASE + 32'h10, 32'hEE, r, g);
    chk("miss_wr_no_ack", 32'(g), 32'd0);
    @(negedge clk);
    chk("miss_no_push", 32'(tx_valid), 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
